// File: rtl/ct_mmu_plru_gen_if.sv
// Hit/refill update, flush, entry status and victim signals between a uTLB array and its PLRU.
// The master drives the update side; the slave returns the registered victim and lock status.
interface ct_mmu_plru_gen_if #(
    parameter int ENTRY_NUM = 32
);
    logic [ENTRY_NUM-1:0] entry_vld;
    logic [ENTRY_NUM-1:0] entry_lock;
    logic                 plru_read_hit_vld;
    logic [ENTRY_NUM-1:0] plru_read_hit;
    logic                 plru_refill_vld;
    logic                 plru_refill_on;
    logic                 plru_flush;
    logic [ENTRY_NUM-1:0] plru_ref_num;
    logic                 plru_all_locked;

    modport master (
        output entry_vld,
        output entry_lock,
        output plru_read_hit_vld,
        output plru_read_hit,
        output plru_refill_vld,
        output plru_refill_on,
        output plru_flush,
        input  plru_ref_num,
        input  plru_all_locked
    );

    modport slave (
        input  entry_vld,
        input  entry_lock,
        input  plru_read_hit_vld,
        input  plru_read_hit,
        input  plru_refill_vld,
        input  plru_refill_on,
        input  plru_flush,
        output plru_ref_num,
        output plru_all_locked
    );
endinterface

// File: rtl/ct_mmu_plru_gen.sv
// Tree-PLRU victim selector (invalid-first, lock-aware); tree updates reach the registered victim 2 edges after the strobe.
// No backpressure: hit/refill/flush are accepted every cycle; refill_on freezes the victim register.
module ct_mmu_plru_gen #(
    parameter int ENTRY_NUM = 32,
    parameter int TREE_W    = ENTRY_NUM - 1
) (
    input  logic                  forever_cpuclk,
    input  logic                  cpurst_b,
    input  logic                  cp0_mmu_icg_en,
    input  logic                  pad_yy_icg_scan_en,
    ct_mmu_plru_gen_if.slave      plru_if
);
    localparam int LVL = $clog2(ENTRY_NUM);

    logic [TREE_W-1:0]    tree_q, tree_d, tree_nxt;
    logic [ENTRY_NUM-1:0] ref_num_q, ref_num_d;
    logic                 all_locked_q, all_locked_d;
    logic [ENTRY_NUM-1:0] unlk, inv_unlk, vic_oh;
    logic [LVL-1:0]       vic_idx;
    logic                 tree_clk_en;

    function automatic logic [LVL-1:0] lowest_idx(input logic [ENTRY_NUM-1:0] v);
        logic [LVL-1:0] r;
        r = '0;
        for (int i = ENTRY_NUM - 1; i >= 0; i--) begin
            if (v[i]) r = LVL'(i);
        end
        return r;
    endfunction

    // Walk root to leaf, pointing every node on the path away from the accessed entry.
    function automatic logic [TREE_W-1:0] tree_access(input logic [TREE_W-1:0] tree,
                                                      input logic [LVL-1:0]    idx);
        logic [TREE_W-1:0] t;
        logic [LVL-1:0]    node;
        logic [LVL-1:0]    sh;
        t = tree;
        for (int l = 0; l < LVL; l++) begin
            node    = LVL'((1 << l) - 1) + LVL'(int'(idx) >> (LVL - l));
            sh      = idx >> (LVL - 1 - l);
            t[node] = ~sh[0];
        end
        return t;
    endfunction

    // Follow node bits, diverting to the sibling when the pointed subtree has no usable entry.
    function automatic logic [LVL-1:0] tree_walk(input logic [TREE_W-1:0]    tree,
                                                 input logic [ENTRY_NUM-1:0] ok);
        logic [LVL-1:0]       k;
        logic [LVL-1:0]       node;
        logic [ENTRY_NUM-1:0] mask;
        logic                 dir, l_ok, r_ok;
        int                   span, k_int;
        k = '0;
        for (int l = 0; l < LVL; l++) begin
            span  = ENTRY_NUM >> (l + 1);
            k_int = int'(k);
            node  = LVL'((1 << l) - 1) + k;
            dir   = tree[node];
            mask  = (ENTRY_NUM'(1) << span) - ENTRY_NUM'(1);
            l_ok  = |((ok >> (2 * k_int * span)) & mask);
            r_ok  = |((ok >> ((2 * k_int + 1) * span)) & mask);
            if (!dir && !l_ok) begin
                dir = 1'b1;
            end else if (dir && !r_ok) begin
                dir = 1'b0;
            end
            k = {k[LVL-2:0], dir};
        end
        return k;
    endfunction

    always_comb begin
        unlk     = ~plru_if.entry_lock;
        inv_unlk = ~plru_if.entry_vld & unlk;
        vic_idx  = '0;
        if (|inv_unlk) begin
            vic_idx = lowest_idx(inv_unlk);
        end else if (|unlk) begin
            vic_idx = tree_walk(tree_q, unlk);
        end else begin
            vic_idx = tree_walk(tree_q, '1);
        end
        vic_oh       = ENTRY_NUM'(1) << vic_idx;
        ref_num_d    = plru_if.plru_refill_on ? ref_num_q : vic_oh;
        all_locked_d = &plru_if.entry_lock;
    end

    // Refill is applied before the hit so the hit owns any node both paths share.
    always_comb begin
        tree_nxt = tree_q;
        if (plru_if.plru_flush) begin
            tree_nxt = '0;
        end else begin
            if (plru_if.plru_refill_vld) begin
                tree_nxt = tree_access(tree_nxt, lowest_idx(ref_num_q));
            end
            if (plru_if.plru_read_hit_vld && (|plru_if.plru_read_hit)) begin
                tree_nxt = tree_access(tree_nxt, lowest_idx(plru_if.plru_read_hit));
            end
        end
        // Enable models the tree clock gate; without an event tree_nxt equals tree_q anyway.
        tree_clk_en = plru_if.plru_read_hit_vld | plru_if.plru_refill_vld | plru_if.plru_flush
                    | ~cp0_mmu_icg_en | pad_yy_icg_scan_en;
        tree_d      = tree_clk_en ? tree_nxt : tree_q;
    end

    always_ff @(posedge forever_cpuclk) begin
        if (!cpurst_b) begin
            tree_q       <= '0;
            ref_num_q    <= ENTRY_NUM'(1);
            all_locked_q <= 1'b0;
        end else begin
            tree_q       <= tree_d;
            ref_num_q    <= ref_num_d;
            all_locked_q <= all_locked_d;
        end
    end

    assign plru_if.plru_ref_num    = ref_num_q;
    assign plru_if.plru_all_locked = all_locked_q;

endmodule

// File: tb/tb_ct_mmu_plru_gen.sv
// Bench for ct_mmu_plru_gen at ENTRY_NUM=8: directed test-plan checks plus a cycle model scoreboard.
module tb_ct_mmu_plru_gen;
    localparam int N = 8;

    typedef struct {
        logic [7:0] ref_num;
        logic       all_locked;
    } exp_t;

    logic clk;
    logic rst_b;
    logic icg_en;
    logic scan_en;
    int   n_cmp;
    int   n_bad;

    exp_t       exp_q[$];
    logic [6:0] m_tree;
    logic [7:0] m_ref;
    logic       m_al;

    ct_mmu_plru_gen_if #(.ENTRY_NUM(N)) pif ();

    ct_mmu_plru_gen #(.ENTRY_NUM(N)) dut (
        .forever_cpuclk     (clk),
        .cpurst_b           (rst_b),
        .cp0_mmu_icg_en     (icg_en),
        .pad_yy_icg_scan_en (scan_en),
        .plru_if            (pif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic int m_lowest(input logic [7:0] v);
        for (int i = 0; i < 8; i++) if (v[i]) return i;
        return 0;
    endfunction

    function automatic logic [6:0] m_access(input logic [6:0] t, input int e);
        logic [6:0] r;
        int         n, p;
        r = t;
        n = e + 7;
        while (n > 0) begin
            p    = (n - 1) / 2;
            r[p] = (n == 2 * p + 1);
            n    = p;
        end
        return r;
    endfunction

    function automatic int m_walk(input logic [6:0] t, input logic [7:0] ok);
        logic av[15];
        int   n, c;
        for (int i = 0; i < 8; i++) av[7 + i] = ok[i];
        for (int i = 6; i >= 0; i--) av[i] = av[2 * i + 1] | av[2 * i + 2];
        n = 0;
        while (n < 7) begin
            c = t[n] ? 2 * n + 2 : 2 * n + 1;
            if (!av[c]) c = t[n] ? 2 * n + 1 : 2 * n + 2;
            n = c;
        end
        return n - 7;
    endfunction

    function automatic int m_victim(input logic [6:0] t, input logic [7:0] v, input logic [7:0] l);
        for (int i = 0; i < 8; i++) if (!v[i] && !l[i]) return i;
        if (l != 8'hFF) return m_walk(t, ~l);
        return m_walk(t, 8'hFF);
    endfunction

    // Advance the model across one edge, queue its outputs, then compare after the edge.
    task automatic step();
        logic [7:0] nref;
        logic [6:0] ntree;
        exp_t       e, got;
        if (!rst_b) begin
            m_tree = '0;
            m_ref  = 8'h01;
            m_al   = 1'b0;
        end else begin
            nref  = pif.plru_refill_on ? m_ref
                  : (8'h01 << m_victim(m_tree, pif.entry_vld, pif.entry_lock));
            ntree = m_tree;
            if (pif.plru_flush) begin
                ntree = '0;
            end else begin
                if (pif.plru_refill_vld) ntree = m_access(ntree, m_lowest(m_ref));
                if (pif.plru_read_hit_vld && pif.plru_read_hit != 0)
                    ntree = m_access(ntree, m_lowest(pif.plru_read_hit));
            end
            m_al   = &pif.entry_lock;
            m_ref  = nref;
            m_tree = ntree;
        end
        e.ref_num    = m_ref;
        e.all_locked = m_al;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        got = exp_q.pop_front();
        check("sb_ref", 32'(pif.plru_ref_num), 32'(got.ref_num));
        check("sb_all_locked", 32'(pif.plru_all_locked), 32'(got.all_locked));
    endtask

    task automatic idle_inputs();
        pif.plru_read_hit_vld = 1'b0;
        pif.plru_read_hit     = '0;
        pif.plru_refill_vld   = 1'b0;
        pif.plru_flush        = 1'b0;
    endtask

    task automatic do_reset();
        rst_b = 1'b0;
        idle_inputs();
        pif.plru_refill_on = 1'b0;
        pif.entry_vld      = 8'hFF;
        pif.entry_lock     = 8'h00;
        step();
        step();
        rst_b = 1'b1;
    endtask

    task automatic hit_vec(input logic [7:0] v);
        pif.plru_read_hit_vld = 1'b1;
        pif.plru_read_hit     = v;
        step();
        idle_inputs();
    endtask

    initial begin
        n_cmp   = 0;
        n_bad   = 0;
        icg_en  = 1'b1;
        scan_en = 1'b0;
        m_tree  = '0;
        m_ref   = 8'h01;
        m_al    = 1'b0;

        // reset and hit sequence, then invalid-first
        do_reset();
        step();
        check("rst_ref", 32'(pif.plru_ref_num), 32'h01);
        check("rst_all_locked", 32'(pif.plru_all_locked), 32'h0);
        hit_vec(8'h01); step();
        check("hit0", 32'(pif.plru_ref_num), 32'h10);
        hit_vec(8'h10); step();
        check("hit4", 32'(pif.plru_ref_num), 32'h04);
        pif.entry_vld = 8'hF7; step();
        check("invalid_first", 32'(pif.plru_ref_num), 32'h08);
        pif.entry_lock = 8'h08; step();
        check("invalid_locked", 32'(pif.plru_ref_num), 32'h04);

        // lock steering and all-locked fallback
        do_reset(); step();
        hit_vec(8'h01);
        pif.entry_lock = 8'hF0; step();
        check("lock_f0", 32'(pif.plru_ref_num), 32'h04);
        pif.entry_lock = 8'hFF; step();
        check("all_locked_flag", 32'(pif.plru_all_locked), 32'h1);
        check("all_locked_ref", 32'(pif.plru_ref_num), 32'h10);

        // refill freeze with a concurrent hit
        do_reset(); step();
        pif.plru_refill_on = 1'b1; step();
        check("freeze0", 32'(pif.plru_ref_num), 32'h01);
        pif.plru_refill_vld = 1'b1;
        hit_vec(8'h20);
        check("freeze1", 32'(pif.plru_ref_num), 32'h01);
        step();
        check("freeze2", 32'(pif.plru_ref_num), 32'h01);
        pif.plru_refill_on = 1'b0; step();
        check("freeze_release", 32'(pif.plru_ref_num), 32'h04);

        // multi-bit hit uses lowest index; empty hit vector does nothing
        do_reset(); step();
        hit_vec(8'h0C); step();
        check("multi_hit", 32'(pif.plru_ref_num), 32'h10);
        hit_vec(8'h00); step();
        check("zero_hit", 32'(pif.plru_ref_num), 32'h10);

        // flush beats hit and refill
        do_reset(); step();
        hit_vec(8'h08); hit_vec(8'h40); hit_vec(8'h02);
        pif.plru_flush      = 1'b1;
        pif.plru_refill_vld = 1'b1;
        hit_vec(8'h01); step();
        check("flush", 32'(pif.plru_ref_num), 32'h01);

        // reset while a refill holds the victim
        do_reset(); step();
        hit_vec(8'h01); step();
        check("pre_reset", 32'(pif.plru_ref_num), 32'h10);
        pif.plru_refill_on = 1'b1; step();
        rst_b = 1'b0; step();
        check("reset_mid_refill", 32'(pif.plru_ref_num), 32'h01);
        check("reset_mid_refill_al", 32'(pif.plru_all_locked), 32'h0);
        rst_b = 1'b1;
        pif.plru_refill_on = 1'b0;

        // random traffic against the model, including clock-gate controls
        for (int i = 0; i < 400; i++) begin
            rst_b                 = ($urandom_range(0, 63) != 0);
            icg_en                = 1'($urandom_range(0, 1));
            scan_en               = ($urandom_range(0, 7) == 0);
            pif.plru_read_hit_vld = 1'($urandom_range(0, 1));
            pif.plru_read_hit     = ($urandom_range(0, 3) != 0) ? (8'h01 << $urandom_range(0, 7))
                                                                : 8'($urandom);
            pif.plru_refill_on    = ($urandom_range(0, 3) == 0);
            pif.plru_refill_vld   = ($urandom_range(0, 3) == 0);
            pif.plru_flush        = ($urandom_range(0, 15) == 0);
            pif.entry_vld         = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'hFF;
            case ($urandom_range(0, 5))
                0:       pif.entry_lock = 8'($urandom);
                1:       pif.entry_lock = 8'hFF;
                default: pif.entry_lock = 8'h00;
            endcase
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
